// File: rtl/dm_log_pkg.sv
// Shared types for the data-memory store logger.
// DM_LOG_TSTAMP_EN adds a capture timestamp to every log entry.
package dm_log_pkg;

  localparam int unsigned TSTAMP_W = 32;
  // Entry fields are sized for the widest supported bus; narrower N zero-extends.
  localparam int unsigned DM_LOG_N = 64;

  typedef enum logic [1:0] {
    StCapture,
    StDrain,
    StDone
  } dm_log_state_e;

  typedef struct packed {
    logic [DM_LOG_N-1:0] addr;
    logic [DM_LOG_N-1:0] data;
`ifdef DM_LOG_TSTAMP_EN
    logic [TSTAMP_W-1:0] tstamp;
`endif
  } dm_log_entry_t;

endpackage

// File: rtl/dm_log_fifo.sv
// Synchronous FIFO; full/empty come from the occupancy counter so that
// pointer equality is never ambiguous. Depth must be a power of two >= 2.
module dm_log_fifo #(
  parameter int unsigned Width = 128,
  parameter int unsigned Depth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage array, no reset needed: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dm_write_logger.sv
// Passive store-trace logger for the processor data-memory write port.
// Captures committed stores into a FIFO and drains them over valid/ready on a
// rising edge of dump. Optional macro DM_LOG_TSTAMP_EN adds log_tstamp.
// N must not exceed dm_log_pkg::DM_LOG_N.
module dm_write_logger
  import dm_log_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   DM_writeEnable,
  input  logic [N-1:0]           DM_addr,
  input  logic [N-1:0]           DM_writeData,
  input  logic                   dump,
  input  logic                   log_ready,
  output logic                   log_valid,
  output logic [N-1:0]           log_addr,
  output logic [N-1:0]           log_data,
  output logic                   log_done,
  output logic                   overflow,
`ifdef DM_LOG_TSTAMP_EN
  output logic [TSTAMP_W-1:0]    log_tstamp,
`endif
  output logic [$clog2(DEPTH):0] count
);

  dm_log_state_e state_q, state_d;
  logic          dump_q;
  logic          dump_edge;
  logic          valid_q, valid_d;
  logic [N-1:0]  addr_q, addr_d, data_q, data_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, fifo_full, fifo_empty;
  dm_log_entry_t entry_in, entry_head;

`ifdef DM_LOG_TSTAMP_EN
  logic [TSTAMP_W-1:0] tstamp_cnt_q, tstamp_q, tstamp_d;

  // Free-running cycle counter, wraps at 2^32.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) tstamp_cnt_q <= '0;
    else        tstamp_cnt_q <= tstamp_cnt_q + 1'b1;
  end

  assign entry_in.tstamp = tstamp_cnt_q;
  assign log_tstamp      = tstamp_q;
`endif

  assign entry_in.addr = DM_LOG_N'(DM_addr);
  assign entry_in.data = DM_LOG_N'(DM_writeData);
  assign dump_edge     = dump && !dump_q;

  dm_log_fifo #(
    .Width($bits(dm_log_entry_t)),
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i  (CLOCK_50),
    .rst_ni (reset),
    .push_i (push),
    .data_i (entry_in),
    .pop_i  (pop),
    .data_o (entry_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(count)
  );

  // Next-state: capture stores, drain through the output register, wait for dump release.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    pop     = 1'b0;
`ifdef DM_LOG_TSTAMP_EN
    tstamp_d = tstamp_q;
`endif
    unique case (state_q)
      StCapture: begin
        if (DM_writeEnable) begin
          if (fifo_full) ovf_d = 1'b1;
          else           push  = 1'b1;
        end
        if (dump_edge) state_d = StDrain;
      end
      StDrain: begin
        if (DM_writeEnable) ovf_d = 1'b1;
        // Output register is free when empty or its beat is being taken.
        if (!valid_q || log_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            valid_d = 1'b1;
            addr_d  = entry_head.addr[N-1:0];
            data_d  = entry_head.data[N-1:0];
`ifdef DM_LOG_TSTAMP_EN
            tstamp_d = entry_head.tstamp;
`endif
          end else begin
            valid_d = 1'b0;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (DM_writeEnable) ovf_d = 1'b1;
        if (!dump) begin
          state_d = StCapture;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StCapture;
    endcase
  end

  // State, dump history and output registers.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= StCapture;
      dump_q  <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef DM_LOG_TSTAMP_EN
      tstamp_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      dump_q  <= dump;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
`ifdef DM_LOG_TSTAMP_EN
      tstamp_q <= tstamp_d;
`endif
    end
  end

  assign log_valid = valid_q;
  assign log_addr  = addr_q;
  assign log_data  = data_q;
  assign log_done  = (state_q == StDone);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_dm_write_logger.sv
// Directed bench for dm_write_logger: table of per-cycle vectors plus
// hand-written sequences for overflow, reset-during-drain and timestamps.
module tb_dm_write_logger;

  localparam int unsigned N     = 64;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [N-1:0]  addr, wdata;
  logic          dump, ready;
  logic          valid, done, ovf;
  logic [N-1:0]  laddr, ldata;
  logic [4:0]    cnt;
`ifdef DM_LOG_TSTAMP_EN
  logic [31:0]   tstamp;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dm_write_logger #(
    .N(N),
    .DEPTH(DEPTH)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (rst_n),
    .DM_writeEnable(we),
    .DM_addr       (addr),
    .DM_writeData  (wdata),
    .dump          (dump),
    .log_ready     (ready),
    .log_valid     (valid),
    .log_addr      (laddr),
    .log_data      (ldata),
    .log_done      (done),
    .overflow      (ovf),
`ifdef DM_LOG_TSTAMP_EN
    .log_tstamp    (tstamp),
`endif
    .count         (cnt)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
    logic        dump;
    logic        ready;
    logic        e_valid;
    logic [63:0] e_addr;
    logic [63:0] e_data;
    logic        e_done;
    logic        e_ovf;
    logic [63:0] e_count;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ts0;
    ts0 = '0;
    rst_n = 1'b0; we = 1'b0; addr = '0; wdata = '0; dump = 1'b0; ready = 1'b0;

    // we addr data dump ready | valid addr data done ovf count
    vecs[0]  = '{1'b1, 64'h10, 64'hA,  1'b0, 1'b1, 1'b0, 64'h0,  64'h0, 1'b0, 1'b0, 64'd1};
    vecs[1]  = '{1'b1, 64'h18, 64'hB,  1'b0, 1'b1, 1'b0, 64'h0,  64'h0, 1'b0, 1'b0, 64'd2};
    vecs[2]  = '{1'b1, 64'h20, 64'hC,  1'b0, 1'b1, 1'b0, 64'h0,  64'h0, 1'b0, 1'b0, 64'd3};
    vecs[3]  = '{1'b0, 64'h0,  64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  64'h0, 1'b0, 1'b0, 64'd3};
    vecs[4]  = '{1'b0, 64'h0,  64'h0,  1'b1, 1'b1, 1'b1, 64'h10, 64'hA, 1'b0, 1'b0, 64'd2};
    vecs[5]  = '{1'b0, 64'h0,  64'h0,  1'b1, 1'b1, 1'b1, 64'h18, 64'hB, 1'b0, 1'b0, 64'd1};
    vecs[6]  = '{1'b0, 64'h0,  64'h0,  1'b1, 1'b1, 1'b1, 64'h20, 64'hC, 1'b0, 1'b0, 64'd0};
    vecs[7]  = '{1'b0, 64'h0,  64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  64'h0, 1'b1, 1'b0, 64'd0};
    vecs[8]  = '{1'b0, 64'h0,  64'h0,  1'b0, 1'b0, 1'b0, 64'h0,  64'h0, 1'b0, 1'b0, 64'd0};
    vecs[9]  = '{1'b1, 64'h40, 64'h1,  1'b0, 1'b0, 1'b0, 64'h0,  64'h0, 1'b0, 1'b0, 64'd1};
    vecs[10] = '{1'b1, 64'h48, 64'h2,  1'b0, 1'b0, 1'b0, 64'h0,  64'h0, 1'b0, 1'b0, 64'd2};
    // Store on the same edge that samples the dump rise.
    vecs[11] = '{1'b1, 64'h50, 64'h3,  1'b1, 1'b0, 1'b0, 64'h0,  64'h0, 1'b0, 1'b0, 64'd3};
    vecs[12] = '{1'b0, 64'h0,  64'h0,  1'b1, 1'b1, 1'b1, 64'h40, 64'h1, 1'b0, 1'b0, 64'd2};
    vecs[13] = '{1'b0, 64'h0,  64'h0,  1'b1, 1'b1, 1'b1, 64'h48, 64'h2, 1'b0, 1'b0, 64'd1};
    // Stall with a store arriving during drain.
    vecs[14] = '{1'b1, 64'h99, 64'hFF, 1'b1, 1'b0, 1'b1, 64'h48, 64'h2, 1'b0, 1'b1, 64'd1};
    vecs[15] = '{1'b0, 64'h0,  64'h0,  1'b1, 1'b0, 1'b1, 64'h48, 64'h2, 1'b0, 1'b1, 64'd1};
    vecs[16] = '{1'b0, 64'h0,  64'h0,  1'b1, 1'b1, 1'b1, 64'h50, 64'h3, 1'b0, 1'b1, 64'd0};
    vecs[17] = '{1'b0, 64'h0,  64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  64'h0, 1'b1, 1'b1, 64'd0};
    vecs[18] = '{1'b0, 64'h0,  64'h0,  1'b0, 1'b0, 1'b0, 64'h0,  64'h0, 1'b0, 1'b0, 64'd0};

    // Reset state.
    step();
    step();
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_count", 64'(cnt), 64'd0);
    check("rst_addr", laddr, 64'd0);
    check("rst_data", ldata, 64'd0);
    rst_n = 1'b1;
    step();

    // Basic drain, stall handling, same-cycle store and drain-time drop.
    for (int i = 0; i < 19; i++) begin
      we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].data;
      dump = vecs[i].dump; ready = vecs[i].ready;
      step();
      check($sformatf("v%0d_valid", i), 64'(valid), 64'(vecs[i].e_valid));
      check($sformatf("v%0d_done", i), 64'(done), 64'(vecs[i].e_done));
      check($sformatf("v%0d_ovf", i), 64'(ovf), 64'(vecs[i].e_ovf));
      check($sformatf("v%0d_count", i), 64'(cnt), vecs[i].e_count);
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d_addr", i), laddr, vecs[i].e_addr);
        check($sformatf("v%0d_data", i), ldata, vecs[i].e_data);
      end
    end

    // Overflow: 17 stores into a 16-deep log.
    we = 1'b0; dump = 1'b0; ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      we = 1'b1; addr = 64'h1000 + 64'(i * 8); wdata = 64'hD000 + 64'(i);
      step();
      if (i == 15) begin
        check("ovf16_count", 64'(cnt), 64'd16);
        check("ovf16_flag", 64'(ovf), 64'd0);
      end
    end
    check("ovf17_count", 64'(cnt), 64'd16);
    check("ovf17_flag", 64'(ovf), 64'd1);
    we = 1'b0; dump = 1'b1; ready = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("ovf_beat%0d_valid", i), 64'(valid), 64'd1);
      check($sformatf("ovf_beat%0d_addr", i), laddr, 64'h1000 + 64'(i * 8));
      check($sformatf("ovf_beat%0d_data", i), ldata, 64'hD000 + 64'(i));
    end
    step();
    check("ovf_done", 64'(done), 64'd1);
    check("ovf_end_valid", 64'(valid), 64'd0);
    check("ovf_held", 64'(ovf), 64'd1);
    dump = 1'b0;
    step();
    check("ovf_cleared", 64'(ovf), 64'd0);

    // Reset during drain, after the second beat is presented.
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; addr = 64'h2000 + 64'(i); wdata = 64'hE0 + 64'(i);
      step();
    end
    we = 1'b0; dump = 1'b1; ready = 1'b1;
    step();
    step();
    check("rd_beat0", laddr, 64'h2000);
    step();
    check("rd_beat1", laddr, 64'h2001);
    ready = 1'b0; dump = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rd_rst_valid", 64'(valid), 64'd0);
    check("rd_rst_count", 64'(cnt), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    dump = 1'b1; ready = 1'b1;
    step();
    check("rd_redump_valid", 64'(valid), 64'd0);
    check("rd_redump_notdone", 64'(done), 64'd0);
    step();
    check("rd_redump_done", 64'(done), 64'd1);
    check("rd_redump_novalid", 64'(valid), 64'd0);
    dump = 1'b0;
    step();

`ifdef DM_LOG_TSTAMP_EN
    // Two stores five cycles apart.
    we = 1'b1; addr = 64'h3000; wdata = 64'h1;
    step();
    we = 1'b0;
    for (int i = 0; i < 4; i++) step();
    we = 1'b1; addr = 64'h3008; wdata = 64'h2;
    step();
    we = 1'b0; dump = 1'b1; ready = 1'b1;
    step();
    step();
    check("ts_beat0_addr", laddr, 64'h3000);
    ts0 = tstamp;
    step();
    check("ts_beat1_addr", laddr, 64'h3008);
    check("ts_delta", 64'(tstamp - ts0), 64'd5);
    step();
    dump = 1'b0;
    step();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
